sensor_hub: RTL and testbench

Input-side front end for the smart-home `Mealy` controller. It conditions the raw door, window and fire-alarm contacts: each is synchronized and debounced before it drives `SFD`, `SRD`, `SW` and `SFA`. It also receives the temperature sensor's serial frame and presents the decoded value on `ST[6:0]`. Its outputs connect directly to the controller's inputs of the same names.

---
 rtl/sensor_hub_if.sv | 28 ++
 rtl/sensor_hub.sv | 200 ++++++++++++++++++++
 tb/tb_sensor_hub.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sensor_hub_if.sv
`timescale 1ns/1ps
// Signal bundle between the raw sensor wiring and the hub: raw contacts and the
// temperature serial line in, conditioned contacts and decoded temperature out.
interface sensor_hub_if;
    logic       raw_fd;
    logic       raw_rd;
    logic       raw_w;
    logic       raw_fa;
    logic       ts_rx;
    logic       SFD;
    logic       SRD;
    logic       SW;
    logic       SFA;
    logic [6:0] ST;
    logic       st_valid;
    logic       st_err;

    // master: the sensor side driving raw lines; slave: the hub itself
    modport master (
        output raw_fd, raw_rd, raw_w, raw_fa, ts_rx,
        input  SFD, SRD, SW, SFA, ST, st_valid, st_err
    );

    modport slave (
        input  raw_fd, raw_rd, raw_w, raw_fa, ts_rx,
        output SFD, SRD, SW, SFA, ST, st_valid, st_err
    );
endinterface

// File: rtl/sensor_hub.sv
`timescale 1ns/1ps
// sensor_hub: synchronizes and debounces the four door/window/alarm contacts and
// decodes the temperature sensor's 7-bit even-parity serial frame onto ST.
module sensor_hub #(
    parameter int         DEB_CYCLES = 4,
    parameter int         BIT_CYCLES = 8,
    parameter logic [6:0] ST_INIT    = 7'd25
) (
    input  logic        clk,
    input  logic        Rst_n,
    sensor_hub_if.slave bus
);
    localparam int DEB_W = $clog2(DEB_CYCLES);
    localparam int BIT_W = $clog2(BIT_CYCLES);
    localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [BIT_W-1:0] HALF_LAST = BIT_W'(BIT_CYCLES / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(BIT_CYCLES - 1);

    logic [3:0] raw_vec;
    logic [3:0] deb_vec;

    assign raw_vec = {bus.raw_fa, bus.raw_w, bus.raw_rd, bus.raw_fd};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi = gi + 1) begin : g_deb
            logic             sync1_reg;
            logic             sync2_reg;
            logic             deb_reg;
            logic [DEB_W-1:0] cnt_reg;

            // Counter tracks consecutive cycles the synced input disagrees with the output
            always_ff @(posedge clk or negedge Rst_n) begin
                if (!Rst_n) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    deb_reg   <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= raw_vec[gi];
                    sync2_reg <= sync1_reg;
                    if (sync2_reg == deb_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == DEB_LAST) begin
                        deb_reg <= sync2_reg;
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end

            assign deb_vec[gi] = deb_reg;
        end
    endgenerate

    assign bus.SFD = deb_vec[0];
    assign bus.SRD = deb_vec[1];
    assign bus.SW  = deb_vec[2];
    assign bus.SFA = deb_vec[3];

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } rx_state_t;

    rx_state_t        state_reg,  state_next;
    logic [BIT_W-1:0] cnt_reg,    cnt_next;
    logic [2:0]       idx_reg,    idx_next;
    logic [6:0]       shift_reg,  shift_next;
    logic             parity_reg, parity_next;
    logic [6:0]       st_reg,     st_next;
    logic             valid_reg,  valid_next;
    logic             err_reg,    err_next;
    logic             rx_sync1_reg;
    logic             rx_sync2_reg;
    logic             bit_tick;

    // The line idles high, so its synchronizer resets high to avoid a phantom start bit
    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rx_sync1_reg <= 1'b1;
            rx_sync2_reg <= 1'b1;
        end else begin
            rx_sync1_reg <= bus.ts_rx;
            rx_sync2_reg <= rx_sync1_reg;
        end
    end

    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_reg  <= S_IDLE;
            cnt_reg    <= '0;
            idx_reg    <= '0;
            shift_reg  <= '0;
            parity_reg <= 1'b0;
            st_reg     <= ST_INIT;
            valid_reg  <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            idx_reg    <= idx_next;
            shift_reg  <= shift_next;
            parity_reg <= parity_next;
            st_reg     <= st_next;
            valid_reg  <= valid_next;
            err_reg    <= err_next;
        end
    end

    assign bit_tick = (cnt_reg == BIT_LAST);

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        idx_next    = idx_reg;
        shift_next  = shift_reg;
        parity_next = parity_reg;
        st_next     = st_reg;
        valid_next  = 1'b0;
        err_next    = 1'b0;

        unique case (state_reg)
            S_IDLE: begin
                if (!rx_sync2_reg) begin
                    state_next = S_START;
                    cnt_next   = '0;
                end
            end
            // Half a bit in, re-check the line to reject glitches shorter than that
            S_START: begin
                if (cnt_reg == HALF_LAST) begin
                    cnt_next   = '0;
                    idx_next   = '0;
                    state_next = rx_sync2_reg ? S_IDLE : S_DATA;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_DATA: begin
                if (bit_tick) begin
                    cnt_next   = '0;
                    shift_next = {rx_sync2_reg, shift_reg[6:1]};
                    if (idx_reg == 3'd6) begin
                        state_next = S_PARITY;
                    end else begin
                        idx_next = idx_reg + 3'd1;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_PARITY: begin
                if (bit_tick) begin
                    cnt_next    = '0;
                    parity_next = rx_sync2_reg;
                    state_next  = S_STOP;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_STOP: begin
                if (bit_tick) begin
                    cnt_next = '0;
                    if (!rx_sync2_reg) begin
                        err_next   = 1'b1;
                        state_next = S_BREAK;
                    end else if (^{shift_reg, parity_reg} == 1'b0) begin
                        st_next    = shift_reg;
                        valid_next = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        err_next   = 1'b1;
                        state_next = S_IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            // A line stuck low after a framing error must not look like endless start bits
            S_BREAK: begin
                if (rx_sync2_reg) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign bus.ST       = st_reg;
    assign bus.st_valid = valid_reg;
    assign bus.st_err   = err_reg;
endmodule

// File: tb/tb_sensor_hub.sv
`timescale 1ns/1ps
// Bench for sensor_hub: directed test-plan scenarios plus randomized contacts and
// frames, all compared every cycle against a window/event-based reference model.
module tb_sensor_hub;
    localparam int         DEB     = 4;
    localparam int         BITC    = 8;
    localparam logic [6:0] ST_INIT = 7'd25;
    // Two synchronizer edges, then the FSM's first low sample is edge t; stop sample is t+BITC/2+9*BITC
    localparam int         FRAME_LAT = 3 + BITC / 2 + 9 * BITC;

    logic clk   = 1'b0;
    logic Rst_n = 1'b0;

    sensor_hub_if hub_if();

    sensor_hub #(
        .DEB_CYCLES(DEB),
        .BIT_CYCLES(BITC),
        .ST_INIT   (ST_INIT)
    ) dut (
        .clk  (clk),
        .Rst_n(Rst_n),
        .bus  (hub_if.slave)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        int         at;
        bit         is_err;
        logic [6:0] val;
    } ev_t;

    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc      = 0;
    bit         chk_en   = 1'b0;
    bit         frames_done = 1'b0;
    ev_t        evq[$];
    bit         r_hist [4][DEB+2];
    bit [3:0]   m_out    = 4'b0;
    logic [6:0] m_st     = ST_INIT;
    bit         m_valid  = 1'b0;
    bit         m_err    = 1'b0;
    bit [3:0]   raw_now;
    bit         all_diff;
    ev_t        ev_pop;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference model: an output flips once the last DEB synced samples all disagree
    // with it; frame results are scheduled events fixed when the frame is launched.
    initial forever begin
        @(posedge clk or negedge Rst_n);
        if (!Rst_n) begin
            for (int c = 0; c < 4; c++)
                for (int j = 0; j < DEB + 2; j++)
                    r_hist[c][j] = 1'b0;
            m_out   = 4'b0;
            m_st    = ST_INIT;
            m_valid = 1'b0;
            m_err   = 1'b0;
            evq.delete();
        end else begin
            cyc++;
            raw_now = {hub_if.raw_fa, hub_if.raw_w, hub_if.raw_rd, hub_if.raw_fd};
            for (int c = 0; c < 4; c++) begin
                for (int j = DEB + 1; j > 0; j--)
                    r_hist[c][j] = r_hist[c][j-1];
                r_hist[c][0] = raw_now[c];
                all_diff = 1'b1;
                for (int j = 2; j < DEB + 2; j++)
                    if (r_hist[c][j] == m_out[c]) all_diff = 1'b0;
                if (all_diff) m_out[c] = r_hist[c][2];
            end
            m_valid = 1'b0;
            m_err   = 1'b0;
            if (evq.size() > 0 && evq[0].at == cyc) begin
                ev_pop = evq.pop_front();
                if (ev_pop.is_err) begin
                    m_err = 1'b1;
                end else begin
                    m_valid = 1'b1;
                    m_st    = ev_pop.val;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("SFD",      32'(hub_if.SFD),      32'(m_out[0]));
            check("SRD",      32'(hub_if.SRD),      32'(m_out[1]));
            check("SW",       32'(hub_if.SW),       32'(m_out[2]));
            check("SFA",      32'(hub_if.SFA),      32'(m_out[3]));
            check("ST",       32'(hub_if.ST),       32'(m_st));
            check("st_valid", 32'(hub_if.st_valid), 32'(m_valid));
            check("st_err",   32'(hub_if.st_err),   32'(m_err));
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic set_raw(input int ch, input bit v);
        case (ch)
            0:       hub_if.raw_fd = v;
            1:       hub_if.raw_rd = v;
            2:       hub_if.raw_w  = v;
            default: hub_if.raw_fa = v;
        endcase
    endtask

    // kind: 0 good, 1 bad parity, 2 stop bit low; abort_at>0 resets the hub before that bit
    task automatic send_frame(input logic [6:0] d, input int kind, input int low_hold,
                              input int abort_at);
        logic [9:0] bits;
        ev_t        ev;
        bits = {(kind == 2) ? 1'b0 : 1'b1, (kind == 1) ? ~(^d) : (^d), d, 1'b0};
        if (abort_at == 0) begin
            ev.at     = cyc + FRAME_LAT;
            ev.is_err = (kind != 0);
            ev.val    = d;
            evq.push_back(ev);
        end
        for (int i = 0; i < 10; i++) begin
            if (abort_at != 0 && i == abort_at) begin
                Rst_n        = 1'b0;
                hub_if.ts_rx = 1'b1;
                idle(3);
                Rst_n = 1'b1;
                return;
            end
            hub_if.ts_rx = bits[i];
            idle(BITC);
        end
        if (kind == 2) begin
            idle(low_hold);
            hub_if.ts_rx = 1'b1;
            idle(4);
        end
    endtask

    task automatic random_frames();
        int k;
        for (int f = 0; f < 20; f++) begin
            k = int'($urandom_range(0, 5));
            send_frame(7'($urandom_range(0, 127)), (k < 4) ? 0 : k - 3,
                       int'($urandom_range(0, 30)), 0);
            idle(int'($urandom_range(0, 4)));
        end
        frames_done = 1'b1;
    endtask

    task automatic random_contacts();
        while (!frames_done) begin
            set_raw(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            idle(int'($urandom_range(1, 8)));
        end
    endtask

    initial begin
        hub_if.raw_fd = 1'b0;
        hub_if.raw_rd = 1'b0;
        hub_if.raw_w  = 1'b0;
        hub_if.raw_fa = 1'b0;
        hub_if.ts_rx  = 1'b1;
        @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        #1;

        // Reset holds every output while contacts toggle
        for (int i = 0; i < 8; i++) begin
            for (int c = 0; c < 4; c++) set_raw(c, 1'(i + c));
            idle(1);
        end
        check("rst_SFD", 32'(hub_if.SFD), 32'd0);
        check("rst_SFA", 32'(hub_if.SFA), 32'd0);
        check("rst_ST",  32'(hub_if.ST),  32'd25);
        for (int c = 0; c < 4; c++) set_raw(c, 1'b0);
        Rst_n = 1'b1;
        idle(10);
        check("post_rst_ST", 32'(hub_if.ST), 32'd25);
        check("post_rst_SW", 32'(hub_if.SW), 32'd0);

        // Short pulse is filtered; a held level lands exactly 2+DEB edges later
        hub_if.raw_fd = 1'b1;
        idle(3);
        hub_if.raw_fd = 1'b0;
        idle(10);
        check("sfd_short", 32'(hub_if.SFD), 32'd0);
        hub_if.raw_fd = 1'b1;
        repeat (5) @(negedge clk);
        check("sfd_lat5", 32'(hub_if.SFD), 32'd0);
        @(negedge clk);
        check("sfd_lat6", 32'(hub_if.SFD), 32'd1);
        #1;
        idle(4);
        hub_if.raw_fd = 1'b0;
        idle(10);

        for (int i = 0; i < 36; i++) begin
            if (i == 9)  check("sfa_short", 32'(hub_if.SFA), 32'd0);
            if (i == 15) check("sfa_lat5",  32'(hub_if.SFA), 32'd0);
            if (i == 16) check("sfa_lat6",  32'(hub_if.SFA), 32'd1);
            hub_if.raw_w  = ~hub_if.raw_w;
            hub_if.raw_fa = (i < 3) || (i >= 10 && i < 25);
            idle(1);
        end
        check("sw_toggle", 32'(hub_if.SW), 32'd0);
        hub_if.raw_w = 1'b0;
        idle(10);

        // Frames: valid, bad parity, framing error with a stuck-low line, glitch, valid
        send_frame(7'd40, 0, 0, 0);
        idle(5);
        check("st_40", 32'(hub_if.ST), 32'd40);
        send_frame(7'd90, 1, 0, 0);
        idle(5);
        check("st_parity_hold", 32'(hub_if.ST), 32'd40);
        send_frame(7'd77, 2, 30, 0);
        idle(100);
        check("st_frame_hold", 32'(hub_if.ST), 32'd40);
        hub_if.ts_rx = 1'b0;
        idle(2);
        hub_if.ts_rx = 1'b1;
        idle(20);
        send_frame(7'd18, 0, 0, 0);
        idle(5);
        check("st_18", 32'(hub_if.ST), 32'd18);

        send_frame(7'd60, 0, 0, 4);
        idle(100);
        check("st_abort", 32'(hub_if.ST), 32'd25);

        fork
            random_frames();
            random_contacts();
        join
        for (int c = 0; c < 4; c++) set_raw(c, 1'b0);
        hub_if.ts_rx = 1'b1;
        idle(100);
        check("drain_evq", 32'(evq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
